// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD helpers for the down-counter.
package bcd_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic is_bcd_nibble(input logic [3:0] n);
        return n <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit register with parallel load and borrow-chained decrement.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);
    logic [3:0] digit_q, digit_d;
    always_comb begin
        digit_d = digit_q;
        if (load)
            digit_d = load_val;
        else if (borrow_in)
            digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            digit_q <= 4'd0;
        else
            digit_q <= digit_d;
    end
    assign digit      = digit_q;
    assign borrow_out = (digit_q == 4'd0) & borrow_in;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD countdown timer with validated load,
// optional auto-reload, a terminal-count pulse and a bad-load pulse.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    auto_reload,
    output logic [4*NUM_DIGITS-1:0] cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    load_err
);
    localparam int W = 4*NUM_DIGITS;
    state_t         state_q, state_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           done_q, done_d, err_q, err_d;
    logic           valid, do_load, counting, is_zero, dec, reload_now;
    logic [W-1:0]   digit_load_val;
    logic [NUM_DIGITS:0] borrow;
    always_comb begin
        valid = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            valid = valid & is_bcd_nibble(load_val[4*i +: 4]);
    end
    assign do_load    = load & valid;
    assign counting   = (state_q == ST_RUN) & en;
    assign is_zero    = (cnt == '0);
    assign dec        = counting & ~is_zero & ~do_load;
    // A zero count in RUN only happens after a terminal count with auto_reload set.
    assign reload_now = counting & is_zero & ~do_load;
    assign digit_load_val = do_load ? load_val : reload_q;
    assign borrow[0]  = dec;
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_down_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .load       (do_load | reload_now),
                .load_val   (digit_load_val[4*g +: 4]),
                .borrow_in  (borrow[g]),
                .digit      (cnt[4*g +: 4]),
                .borrow_out (borrow[g+1])
            );
        end
    endgenerate
    always_comb begin
        done_d   = dec & (cnt == W'(1));
        err_d    = load & ~valid;
        reload_d = do_load ? load_val : reload_q;
        state_d  = state_q;
        if (do_load)
            state_d = (load_val != '0) ? ST_RUN : ST_IDLE;
        else if (done_d & ~auto_reload)
            state_d = ST_EXPIRED;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign load_err = err_q;
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed checks of load, countdown, auto-reload and error handling.
module tb_bcd_down_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, load = 1'b0, auto_reload = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] cnt;
    logic       busy, done, load_err;
    int n_vec = 0, n_err = 0;
    logic [7:0] seq12 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    int ndone;
    bcd_down_counter #(.NUM_DIGITS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .cnt(cnt), .busy(busy), .done(done),
        .load_err(load_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #2;
        chk("rst_cnt", cnt, 8'h00);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_done", 8'(done), 8'h0);
        chk("rst_err", 8'(load_err), 8'h0);
        #1 rst = 1'b1;
        // reset mid-run
        load = 1'b1; load_val = 8'h25; tick();
        load = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        chk("mid_cnt", cnt, 8'h22);
        chk("mid_busy", 8'(busy), 8'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst_cnt", cnt, 8'h00);
        chk("arst_busy", 8'(busy), 8'h0);
        chk("arst_done", 8'(done), 8'h0);
        en = 1'b0;
        tick();
        rst = 1'b1;
        // one-shot countdown
        load = 1'b1; load_val = 8'h12; auto_reload = 1'b0; tick();
        chk("os_load", cnt, 8'h12);
        chk("os_busy", 8'(busy), 8'h1);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("os_cnt", cnt, seq12[i]);
            chk("os_done", 8'(done), (i == 11) ? 8'h1 : 8'h0);
        end
        chk("os_busy_exp", 8'(busy), 8'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("exp_hold", cnt, 8'h00);
            chk("exp_done", 8'(done), 8'h0);
        end
        // auto-reload mod-10
        en = 1'b0; load = 1'b1; load_val = 8'h09; auto_reload = 1'b1; tick();
        load = 1'b0; en = 1'b1; ndone = 0;
        for (int k = 0; k < 19; k++) begin
            tick();
            chk("ar_cnt", cnt, 8'((18 - k) % 10));
            chk("ar_busy", 8'(busy), 8'h1);
            if (done) ndone++;
        end
        chk("ar_ndone", 8'(ndone), 8'h2);
        // invalid load mid-run
        en = 1'b0; load = 1'b1; load_val = 8'h10; auto_reload = 1'b0; tick();
        load = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        chk("inv_pre", cnt, 8'h07);
        load = 1'b1; load_val = 8'h3A; tick();
        chk("inv_cnt", cnt, 8'h06);
        chk("inv_err", 8'(load_err), 8'h1);
        chk("inv_done", 8'(done), 8'h0);
        load = 1'b0; tick();
        chk("inv_err_clr", 8'(load_err), 8'h0);
        chk("inv_cnt2", cnt, 8'h05);
        auto_reload = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("inv_zero", cnt, 8'h00);
        chk("inv_zdone", 8'(done), 8'h1);
        tick();
        chk("inv_reload", cnt, 8'h10);
        // load/en collision
        for (int i = 0; i < 5; i++) tick();
        chk("col_pre", cnt, 8'h05);
        load = 1'b1; load_val = 8'h40; tick();
        chk("col_cnt", cnt, 8'h40);
        load = 1'b0; en = 1'b0; tick(); tick();
        chk("col_hold", cnt, 8'h40);
        en = 1'b1; tick();
        chk("col_dec", cnt, 8'h39);
        // high digits borrow
        load = 1'b1; load_val = 8'h99; tick();
        load = 1'b0; tick();
        chk("max_dec", cnt, 8'h98);
        // load zero
        load = 1'b1; load_val = 8'h00; tick();
        load = 1'b0;
        chk("lz_cnt", cnt, 8'h00);
        chk("lz_busy", 8'(busy), 8'h0);
        chk("lz_done", 8'(done), 8'h0);
        tick();
        chk("idle_hold", cnt, 8'h00);
        load = 1'b1; load_val = 8'hA0; tick();
        load = 1'b0;
        chk("idle_err", 8'(load_err), 8'h1);
        chk("idle_inv_cnt", cnt, 8'h00);
        chk("idle_inv_busy", 8'(busy), 8'h0);
        // EXPIRED then reload 01
        load = 1'b1; load_val = 8'h02; auto_reload = 1'b0; tick();
        load = 1'b0; tick(); tick();
        chk("ex_done", 8'(done), 8'h1);
        tick();
        chk("ex_busy", 8'(busy), 8'h0);
        chk("ex_cnt", cnt, 8'h00);
        load = 1'b1; load_val = 8'h01; tick();
        chk("ex_ld_cnt", cnt, 8'h01);
        chk("ex_ld_done", 8'(done), 8'h0);
        chk("ex_ld_busy", 8'(busy), 8'h1);
        load = 1'b0; tick();
        chk("ex_fin_cnt", cnt, 8'h00);
        chk("ex_fin_done", 8'(done), 8'h1);
        chk("ex_fin_busy", 8'(busy), 8'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
